prescaled_counter_gen: RTL

//   Parametrised successor to the PWM timebase prescaled counter. A prescaler divides clk_i by (P+1);

---
 rtl/prescaled_counter_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/prescaled_counter_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prescaled_counter_gen                                        |
// | Description : PWM timebase. A prescaler divides clk_i by (P+1); each       |
// |               prescaler terminal count steps a CNT_W-bit period counter.   |
// |               Adds enable/sleep, a shadowed prescale that only updates at  |
// |               wrap (or while asleep), min-prescale clamping and registered |
// |               tick/wrap strobes.                                           |
// | Option      : define PRESCALED_COUNTER_UPDOWN_EN to add the updown_i port  |
// |               and centre-aligned (up then down) counting.                  |
// | Ports       : clk_i              clock                                     |
// |               rst_ni             asynchronous active-low reset             |
// |               enable_i           1 = run, 0 = sleep (counter cleared/held)  |
// |               prescale_value_i   requested prescale P                      |
// |               counter_ro         period counter (registered)               |
// |               tick_ro            strobe: counter_ro took a new value       |
// |               wrap_ro            strobe: counter_ro returned to period start|
// |               prescale_active_ro shadow prescale in use (post-clamp)       |
// |               updown_i           (option only) 1 = centre-aligned          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module prescaled_counter_gen #(
   parameter int unsigned CNT_W        = 12,
   parameter int unsigned PRESCALE_W   = 8,
   parameter int unsigned PRESCALE_MIN = 3,
   parameter int unsigned PRESCALE_RST = 8'h1E
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic [PRESCALE_W-1:0] prescale_value_i,
   output logic [CNT_W-1:0]      counter_ro,
   output logic                  tick_ro,
   output logic                  wrap_ro,
   output logic [PRESCALE_W-1:0] prescale_active_ro
`ifdef PRESCALED_COUNTER_UPDOWN_EN
  ,input  logic                  updown_i
`endif
);

   localparam logic [PRESCALE_W-1:0] c_prescale_min = PRESCALE_W'(PRESCALE_MIN);
   // Reset shadow never starts below the legal minimum.
   localparam logic [PRESCALE_W-1:0] c_prescale_rst =
      (PRESCALE_RST > PRESCALE_MIN) ? PRESCALE_W'(PRESCALE_RST) : c_prescale_min;
   localparam logic [CNT_W-1:0]      c_cnt_max      = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]      c_cnt_one      = CNT_W'(1);
   localparam logic [PRESCALE_W-1:0] c_presc_one    = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [PRESCALE_W-1:0] prescale_active_q, prescale_active_d;
   logic [CNT_W-1:0]      counter_q, counter_d;
   logic                  tick_q, tick_d;
   logic                  wrap_q, wrap_d;

`ifdef PRESCALED_COUNTER_UPDOWN_EN
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   dir_e dir_q, dir_d;
   // Counting mode latched at wrap / in sleep so a mid-period change is ignored.
   logic updown_q, updown_d;
`endif

   logic [PRESCALE_W-1:0] eff_prescale;
   logic                  terminal;

   assign eff_prescale = (prescale_value_i < c_prescale_min) ? c_prescale_min
                                                             : prescale_value_i;
   assign terminal     = (presc_q == prescale_active_q);

   always_comb begin
      presc_d           = presc_q;
      prescale_active_d = prescale_active_q;
      counter_d         = counter_q;
      tick_d            = 1'b0;
      wrap_d            = 1'b0;
`ifdef PRESCALED_COUNTER_UPDOWN_EN
      dir_d             = dir_q;
      updown_d          = updown_q;
`endif
      if (!enable_i) begin
         // Sleep has priority over a coincident terminal count: no strobe.
         presc_d           = '0;
         counter_d         = '0;
         prescale_active_d = eff_prescale;
`ifdef PRESCALED_COUNTER_UPDOWN_EN
         dir_d             = DIR_UP;
         updown_d          = updown_i;
`endif
      end else if (terminal) begin
         presc_d = '0;
         tick_d  = 1'b1;
`ifdef PRESCALED_COUNTER_UPDOWN_EN
         if (updown_q && (dir_q == DIR_DOWN)) begin
            counter_d = counter_q - c_cnt_one;
            if (counter_q == c_cnt_one) begin
               wrap_d = 1'b1;
               dir_d  = DIR_UP;
            end
         end else if (updown_q && (counter_q == c_cnt_max)) begin
            // Peak reached: turn around without revisiting MAX.
            counter_d = counter_q - c_cnt_one;
            dir_d     = DIR_DOWN;
         end else begin
            counter_d = counter_q + c_cnt_one;
            wrap_d    = (counter_q == c_cnt_max);
         end
`else
         // Natural modular overflow provides the wrap.
         counter_d = counter_q + c_cnt_one;
         wrap_d    = (counter_q == c_cnt_max);
`endif
         if (wrap_d) begin
            prescale_active_d = eff_prescale;
`ifdef PRESCALED_COUNTER_UPDOWN_EN
            updown_d          = updown_i;
`endif
         end
      end else begin
         presc_d = presc_q + c_presc_one;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q           <= '0;
         prescale_active_q <= c_prescale_rst;
         counter_q         <= '0;
         tick_q            <= 1'b0;
         wrap_q            <= 1'b0;
`ifdef PRESCALED_COUNTER_UPDOWN_EN
         dir_q             <= DIR_UP;
         updown_q          <= 1'b0;
`endif
      end else begin
         presc_q           <= presc_d;
         prescale_active_q <= prescale_active_d;
         counter_q         <= counter_d;
         tick_q            <= tick_d;
         wrap_q            <= wrap_d;
`ifdef PRESCALED_COUNTER_UPDOWN_EN
         dir_q             <= dir_d;
         updown_q          <= updown_d;
`endif
      end
   end

   assign counter_ro         = counter_q;
   assign tick_ro            = tick_q;
   assign wrap_ro            = wrap_q;
   assign prescale_active_ro = prescale_active_q;

endmodule
`default_nettype wire
